// File: rtl/uart_tx_if.sv
// Byte handshake between a producer and the UART transmitter.
// A byte moves on a rising edge where tx_valid and tx_ready are both high and the
// transmitter's clock enable is high; tx_ready never depends on tx_valid.
interface uart_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx.sv
// 8N1/8N2 UART transmitter: start bit, eight data bits LSB first, then STOP_BITS stop bits.
// All state advances only on enabled cycles; the serial line is registered.
module uart_tx #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  uart_tx_if.slave   tx,
  output logic       serial_out,
  output logic       busy,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  localparam int STOP_CLKS = CLKS_PER_BIT * STOP_BITS;
  localparam int CW        = (STOP_CLKS > 1) ? $clog2(STOP_CLKS) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_CLKS - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          serial_q, serial_d;
  logic          accept;

  assign tx.tx_ready = (state_q == IDLE) && !rst;
  assign accept      = ena && tx.tx_ready && tx.tx_valid;
  assign serial_out  = serial_q;
  assign busy        = (state_q != IDLE);
  assign dbg_state   = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shreg_q  <= '0;
      serial_q <= 1'b1;
    end else if (ena) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shreg_q  <= shreg_d;
      serial_q <= serial_d;
    end
  end

  // serial_d always carries the level of the bit that the next cycle will show,
  // so each bit boundary loads the following bit one edge early.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shreg_d  = shreg_q;
    serial_d = serial_q;
    case (state_q)
      IDLE: begin
        serial_d = 1'b1;
        if (accept) begin
          state_d  = START;
          shreg_d  = tx.tx_data;
          cnt_d    = '0;
          serial_d = 1'b0;
        end
      end
      START: begin
        if (cnt_q == BIT_LAST) begin
          state_d  = DATA;
          cnt_d    = '0;
          idx_d    = 3'd0;
          serial_d = shreg_q[0];
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            state_d  = STOP;
            serial_d = 1'b1;
          end else begin
            idx_d    = idx_q + 3'd1;
            shreg_d  = {1'b0, shreg_q[7:1]};
            serial_d = shreg_q[1];
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        serial_d = 1'b1;
        if (cnt_q == STOP_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d  = IDLE;
        serial_d = 1'b1;
      end
    endcase
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Parameters
REQ-001 The module SHALL have parameter CLKS_PER_BIT, default 10416, giving clk cycles per serial bit (100 MHz / 9600 baud).
REQ-002 The module SHALL have parameter STOP_BITS, default 1, giving the number of stop bits per frame; legal values are 1 and 2.

Interface
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 ena  input  1  clock enable; while low, all state and outputs SHALL hold.
REQ-006 tx_data  input  8  byte to transmit; sampled only on the accept cycle.
REQ-007 tx_valid  input  1  producer has a byte on tx_data.
REQ-008 tx_ready  output  1  transmitter can accept a byte this cycle.
REQ-009 serial_out  output  1  UART line; idle high, start bit low, data LSB first, stop bit(s) high.
REQ-010 busy  output  1  a frame is in progress (any state other than IDLE).

Function
REQ-011 The FSM SHALL have four states: IDLE, START, DATA, STOP.
REQ-012 Accept SHALL occur on a cycle with ena=1, tx_ready=1 and tx_valid=1; tx_data SHALL be latched into an 8-bit shift register on that edge.
REQ-013 tx_ready SHALL be 1 only in IDLE with rst=0; it SHALL be combinationally independent of tx_valid.
REQ-014 IDLE -> START on accept; serial_out SHALL go low on the cycle immediately after the accept edge (latency 1 cycle).
REQ-015 START SHALL last exactly CLKS_PER_BIT enabled cycles, then transition to DATA with bit index 0.
REQ-016 DATA SHALL drive shift-register bit 0 for CLKS_PER_BIT enabled cycles per bit, shift right, and increment a 3-bit index; after index 7 completes it SHALL transition to STOP.
REQ-017 STOP SHALL drive serial_out=1 for CLKS_PER_BIT*STOP_BITS enabled cycles, then return to IDLE.
REQ-018 A complete frame SHALL occupy (9+STOP_BITS)*CLKS_PER_BIT enabled cycles from the first start-bit cycle to the last stop-bit cycle.
REQ-019 Back-to-back: tx_ready SHALL re-assert on the first cycle after the final stop-bit cycle; an accept there SHALL start the next start bit on the following cycle (1 idle-high cycle between frames).
REQ-020 tx_valid asserted while busy SHALL be ignored; no byte is latched and tx_ready stays 0.
REQ-021 Changes to tx_data after accept SHALL NOT affect the frame in flight.
REQ-022 The baud counter SHALL be wide enough for CLKS_PER_BIT*STOP_BITS-1 and SHALL reload to 0 on every bit boundary; no wrap mid-bit.
REQ-023 ena=0 SHALL freeze counter, index, shift register, state and serial_out; resuming ena SHALL continue the bit with its remaining count.
REQ-024 busy SHALL equal (state != IDLE).

Reset
REQ-025 On a clock edge with rst=1: state=IDLE, counter=0, index=0, shift register=0x00, serial_out=1, busy=0; rst SHALL take priority over ena and tx_valid.
REQ-026 While rst=1, tx_ready SHALL be 0; it SHALL be 1 on the first cycle after rst deasserts.
REQ-027 rst asserted mid-frame SHALL abort the frame; serial_out SHALL be 1 on the cycle after the reset edge, and no partial byte resumes.

Verification (CLKS_PER_BIT=4 unless stated)
REQ-028 Single byte: accept 0xA5 -> serial_out 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles, start bit one cycle after accept, tx_ready back high after 40 cycles.
REQ-029 Back-to-back: bytes 0x3C then 0x7F with tx_valid held high -> two correct frames separated by exactly 1 idle-high cycle; a bench-side UART receiver recovers 0x3C, 0x7F.
REQ-030 Busy ignore: pulse tx_valid with 0xFF during DATA of a 0x00 frame -> frame stays 0x00; 0xFF is never transmitted.
REQ-031 Enable stall: drop ena for 7 cycles mid-bit 3 of 0xC1 -> bit 3 is stretched by exactly 7 cycles; all other bits are 4 cycles; byte is intact.
REQ-032 Reset mid-frame: assert rst during bit 5 of 0x99 -> serial_out=1, busy=0, tx_ready=0 during reset; then accept 0x42 -> clean 0x42 frame.
REQ-033 STOP_BITS=2, CLKS_PER_BIT=10416: send 0xE7 -> stop high for 20832 cycles; frame length 114576 cycles.
